// File: rtl/button_debouncer_pkg.sv
// Purpose : shared types and constants for the push-button debouncer.
// Latency : n/a (declarations only).
// Backpressure: n/a; no flow control in this block.
// Contents: btn_state_t channel state encoding, SYNC_STAGES, counter width helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } btn_state_t;

    localparam int SYNC_STAGES = 2;

    // Bits needed to hold any value in 0..top.
    function automatic int cnt_width(input int top);
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_ch.sv
// Purpose : one debounce channel (state machine, tick counter, optional auto-repeat).
// Latency : level/press/release update on the edge of the DEBOUNCE_TICKS-th tick seen in an ARM state.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
// Ports   : clk, clr (sync, active-high), tick (1-cycle enable), sync_btn (synchronized raw input),
//           btn_level (committed level), btn_press / btn_release (1-cycle pulses).
// Option  : BTN_REPEAT_EN adds auto-repeat press pulses while the button stays held.
module btn_debounce_ch
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic sync_btn,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int CNT_W = cnt_width(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_TICKS);

    // Reject configurations that would make a counter target unreachable.
    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("btn_debounce_ch: tick parameters out of range");
    end

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_done;
    logic             rpt_fire;

    assign cnt_inc  = cnt + CNT_W'(1);
    // The counter only advances while below the target, so it never exceeds it.
    assign cnt_done = tick && (cnt_inc == CNT_TOP);

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] RPT_DELAY_V = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_RATE_V  = RPT_W'(REPEAT_RATE);

    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_inc;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_armed;   // first repeat already issued, now on the faster rate
    logic             in_held;
    logic             rel_commit;

    assign in_held    = (state == HELD) || (state == ARM_RELEASE);
    assign rel_commit = (state == ARM_RELEASE) && !sync_btn && cnt_done;
    assign rpt_inc    = rpt_cnt + RPT_W'(1);
    assign rpt_target = rpt_armed ? RPT_RATE_V : RPT_DELAY_V;
    // No repeat on the edge that commits the release, so press and release never coincide.
    assign rpt_fire   = in_held && !rel_commit && tick && (rpt_inc == rpt_target);

    always_ff @(posedge clk) begin
        if (clr || !in_held || rel_commit) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (tick) begin
            if (rpt_inc == rpt_target) begin
                rpt_cnt   <= '0;
                rpt_armed <= 1'b1;
            end else begin
                rpt_cnt <= rpt_inc;
            end
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= rpt_fire;
            btn_release <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_btn) begin
                        state <= ARM_PRESS;
                        cnt   <= '0;
                    end
                end
                ARM_PRESS: begin
                    // A bounce back to the stable level wins over a same-cycle tick.
                    if (!sync_btn) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt_done) begin
                        state     <= HELD;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else if (tick) begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    if (!sync_btn) begin
                        state <= ARM_RELEASE;
                        cnt   <= '0;
                    end
                end
                ARM_RELEASE: begin
                    if (sync_btn) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt_done) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else if (tick) begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Purpose : debounce N_BTN raw buttons using edges of a slow divider square wave as the sample enable.
// Latency : 3 clk from a raw edge to arming, then commit on the DEBOUNCE_TICKS-th following tick.
// Backpressure: none; outputs are free-running level and single-cycle pulses.
// Ports   : clk, clr (sync, active-high), i_tick_src (async square wave), i_btn[N_BTN] (async raw),
//           o_btn_level / o_btn_press / o_btn_release [N_BTN].
// Option  : define BTN_REPEAT_EN to enable auto-repeat press pulses (REPEAT_DELAY, REPEAT_RATE).
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int N_BTN          = 4,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_tick_src,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_btn_release
);

    logic [SYNC_STAGES-1:0]            tick_sync;
    logic                              tick_d;
    logic [SYNC_STAGES-1:0][N_BTN-1:0] btn_sync;
    logic                              tick;

    // Index 0 is the metastability-catching stage; the top index is the usable output.
    always_ff @(posedge clk) begin
        if (clr) begin
            tick_sync <= '0;
            tick_d    <= 1'b0;
            btn_sync  <= '0;
        end else begin
            tick_sync <= {tick_sync[SYNC_STAGES-2:0], i_tick_src};
            tick_d    <= tick_sync[SYNC_STAGES-1];
            btn_sync  <= {btn_sync[SYNC_STAGES-2:0], i_btn};
        end
    end

    // Divider output is data only: its rising edge becomes a one-cycle enable.
    assign tick = tick_sync[SYNC_STAGES-1] & ~tick_d;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_RATE   (REPEAT_RATE)
        ) u_ch (
            .clk        (clk),
            .clr        (clr),
            .tick       (tick),
            .sync_btn   (btn_sync[SYNC_STAGES-1][g]),
            .btn_level  (o_btn_level[g]),
            .btn_press  (o_btn_press[g]),
            .btn_release(o_btn_release[g])
        );
    end

endmodule
